// File: rtl/mux_arbiter2.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux with bounded grant hold.
// Optional grant statistics counters are enabled by defining MUX_ARB_STATS_EN.
module mux_arbiter2 #(
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4,
  parameter int unsigned STAT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  output logic [1:0]        gnt,
  output logic              s,
  output logic [W-1:0]      m,
  output logic              m_valid,
  output logic              busy
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gnt_cnt0,
  output logic [STAT_W-1:0] gnt_cnt1
`endif
);

  if (MAX_HOLD < 1 || MAX_HOLD > (2**HOLD_W - 1) || STAT_W < 1) begin : g_param_check
    $error("mux_arbiter2: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state;
  state_t              next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                last;
  logic                entering;

  // Release is tested before preemption so a dropped requester is never regranted.
  always_comb begin
    next = IDLE;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   next = G0;
          2'b10:   next = G1;
          2'b11:   next = last ? G0 : G1;
          default: next = IDLE;
        endcase
      end
      G0: begin
        if (!req[0])                              next = req[1] ? G1 : IDLE;
        else if (hold_cnt == HOLD_LAST && req[1]) next = G1;
        else                                      next = G0;
      end
      G1: begin
        if (!req[1])                              next = req[0] ? G0 : IDLE;
        else if (hold_cnt == HOLD_LAST && req[0]) next = G0;
        else                                      next = G1;
      end
      default: next = IDLE;
    endcase
  end

  assign entering = (next != state) && (next == G0 || next == G1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      gnt      <= '0;
      s        <= 1'b0;
      m        <= '0;
      m_valid  <= 1'b0;
    end else begin
      state <= next;
      if (entering) begin
        hold_cnt <= '0;
        last     <= (next == G1);
      end else if ((state == G0 || state == G1) && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      gnt     <= {next == G1, next == G0};
      s       <= (next == G1);
      m_valid <= (next == G0 || next == G1);
      if (next == G0)      m <= x;
      else if (next == G1) m <= y;
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (entering) begin
      if (next == G0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + STAT_W'(1);
      if (next == G1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_arbiter2.sv
// Directed bench for mux_arbiter2: main instance MAX_HOLD=8, second instance MAX_HOLD=1.
module tb_mux_arbiter2;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [0:0] x, y;
  logic [1:0] gnt, gnt_b;
  logic       s, s_b, m_valid, mv_b, busy, busy_b;
  logic [0:0] m, m_b;
`ifdef MUX_ARB_STATS_EN
  logic [1:0] c0, c1, c0_b, c1_b;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mux_arbiter2 #(.W(1), .MAX_HOLD(8), .HOLD_W(4), .STAT_W(2)) dut (
    .clock(clock), .reset(reset), .req(req), .x(x), .y(y),
    .gnt(gnt), .s(s), .m(m), .m_valid(m_valid), .busy(busy)
`ifdef MUX_ARB_STATS_EN
    , .gnt_cnt0(c0), .gnt_cnt1(c1)
`endif
  );

  mux_arbiter2 #(.W(1), .MAX_HOLD(1), .HOLD_W(4), .STAT_W(2)) dut_b (
    .clock(clock), .reset(reset), .req(req), .x(x), .y(y),
    .gnt(gnt_b), .s(s_b), .m(m_b), .m_valid(mv_b), .busy(busy_b)
`ifdef MUX_ARB_STATS_EN
    , .gnt_cnt0(c0_b), .gnt_cnt1(c1_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] eg, input logic es,
                           input logic em, input logic ev, input logic eb);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".s"}, 32'(s), 32'(es));
    check({tag, ".m"}, 32'(m), 32'(em));
    check({tag, ".m_valid"}, 32'(m_valid), 32'(ev));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    logic [1:0] eg;
    reset = 1'b1; req = 2'b00; x = 1'b0; y = 1'b0;
    #2;
    check_out("rst0", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    // single requester x
    req = 2'b01; x = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("single%0d", i), 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    req = 2'b00;
    tick();
    check_out("single_rel", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    reset = 1'b1;
    #1;
    check("rst1.gnt", 32'(gnt), 32'd0);
    #1 reset = 1'b0;

    // tie from reset goes to x, then direct handover to y
    req = 2'b11; x = 1'b1; y = 1'b0;
    tick();
    check_out("tie", 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    req = 2'b10;
    tick();
    check_out("handover", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);

    // async reset while in G1
    x = 1'b0; y = 1'b1;
    tick();
    check_out("g1_y", 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
    #3 reset = 1'b1;
    #1;
    check_out("rst_async", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    // continuous contention: 8-cycle grants (main), alternate every cycle (MAX_HOLD=1)
    req = 2'b11; x = 1'b1; y = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      eg = (((k - 1) / 8) % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("pre%0d.gnt", k), 32'(gnt), 32'(eg));
      check($sformatf("pre%0d.m", k), 32'(m), (eg == 2'b01) ? 32'd1 : 32'd0);
      check($sformatf("alt%0d.gnt", k), 32'(gnt_b), (k % 2 == 1) ? 32'd1 : 32'd2);
    end

    reset = 1'b1;
    #1 reset = 1'b0;

    // saturated hold with no contender, then immediate preemption
    req = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("sat%0d.gnt", k), 32'(gnt), 32'd1);
    end
    req = 2'b11;
    tick();
    check("sat_preempt.gnt", 32'(gnt), 32'd2);
    check("sat_preempt.s", 32'(s), 32'd1);

`ifdef MUX_ARB_STATS_EN
    reset = 1'b1;
    #1 reset = 1'b0;
    req = 2'b01;
    tick();
    check("st1.c0", 32'(c0), 32'd1);
    check("st1.c1", 32'(c1), 32'd0);
    req = 2'b10; tick();
    req = 2'b01; tick();
    req = 2'b10; tick();
    req = 2'b01; tick();
    check("st5.c0", 32'(c0), 32'd3);
    check("st5.c1", 32'(c1), 32'd2);
    for (int i = 0; i < 6; i++) begin
      req = 2'b00; tick();
      req = 2'b01; tick();
    end
    check("stsat.c0", 32'(c0), 32'd3);
    check("stsat.c1", 32'(c1), 32'd2);
    check("stsat.gnt", 32'(gnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
